// File: rtl/sisc_mem_resp_if.sv
// sisc_mem_resp_if: request/response bus between the SISC control FSM
// (initiator) and the memory responder.
//   req    initiator -> responder  access request, held until rdy
//   we     initiator -> responder  1 = write, 0 = read
//   addr   initiator -> responder  word address (AW bits)
//   wdata  initiator -> responder  write data
//   rdata  responder -> initiator  read data, valid while rdy=1
//   rdy    responder -> initiator  one-cycle completion pulse
//   busy   responder -> initiator  responder not idle
//   err    responder -> initiator  out-of-range flag, pulsed with rdy
interface sisc_mem_resp_if #(
  parameter int unsigned AW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          rdy;
  logic          busy;
  logic          err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, rdy, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, rdy, busy, err
  );
endinterface

// File: rtl/sisc_mem_resp.sv
// sisc_mem_resp: single-word memory responder for the SISC datapath.
// Latches a read/write request, waits WAIT_CYC cycles, performs the access
// against an internal DEPTH x 32 array and pulses rdy for one cycle.
// Ports:
//   clk    system clock, rising edge
//   rst_f  asynchronous active-low reset (memory contents are not reset)
//   bus    sisc_mem_resp_if slave modport (req/we/addr/wdata in,
//          rdata/rdy/busy/err out)
// Optional feature macro: MEM_BOUNDS_EN -- when defined, latched addresses
// >= DEPTH flag err with rdy, suppress writes and read back zero. When not
// defined, err is tied low and addresses wrap modulo DEPTH.
module sisc_mem_resp #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 2
) (
  input logic            clk,
  input logic            rst_f,
  sisc_mem_resp_if.slave bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            we_q,    we_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rdy_q,   rdy_d;
  logic            mem_we_c;
  logic [IW-1:0]   idx_c;

  logic [DW-1:0]   mem_q [DEPTH];

  // Array index is the low address bits; anything above is either ignored
  // (wrap) or range-checked below.
  assign idx_c = addr_q[IW-1:0];

`ifdef MEM_BOUNDS_EN
  logic err_q, err_d;
  logic oob_c;

  // Widen by one bit so DEPTH is representable even when AW == IW.
  assign oob_c = ({1'b0, addr_q} >= (AW+1)'(DEPTH));
`else
  logic unused_addr;

  assign unused_addr = ^addr_q;
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rdy_d    = 1'b0;
    mem_we_c = 1'b0;
`ifdef MEM_BOUNDS_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = CW'(WAIT_CYC);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Access edge: memory update / read capture coincide with rdy.
          rdy_d   = 1'b1;
          state_d = S_RESP;
`ifdef MEM_BOUNDS_EN
          if (oob_c) begin
            err_d = 1'b1;
            if (!we_q) begin
              rdata_d = '0;
            end
          end else if (we_q) begin
            mem_we_c = 1'b1;
          end else begin
            rdata_d = mem_q[idx_c];
          end
`else
          if (we_q) begin
            mem_we_c = 1'b1;
          end else begin
            rdata_d = mem_q[idx_c];
          end
`endif
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef MEM_BOUNDS_EN
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Storage array; a reset held across the access edge keeps state_q in
  // S_IDLE, so mem_we_c stays low and the pending write is dropped whole.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[idx_c] <= wdata_q;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rdy   = rdy_q;
  assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: doc/sisc_mem_resp.md
Name: sisc_mem_resp

Overview:
- Memory responder for the SISC datapath; the far end of the control FSM's fetch and mem-state memory accesses.
- Accepts single-word read/write requests from the initiator and services them from an internal word array.
- Inserts a configurable number of wait states, then returns data with a one-cycle rdy pulse.
- Used for both instruction fetch and LOD/STR data accesses.

Parameters:
- AW, 16, request address width in bits.
- DEPTH, 256, number of 32-bit words in the array; must be a power of two.
- WAIT_CYC, 2, wait states inserted before the response; range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_f  input  1  reset, asynchronous and active-low: one clock; reset is asynchronous and active-low.
- req  input  1  access request; initiator holds it high until it sees rdy.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  AW  word address; sampled with req.
- wdata  input  32  write data; sampled with req.
- rdata  output  32  read data; registered, valid while rdy=1, held afterwards.
- rdy  output  1  one-cycle completion pulse.
- busy  output  1  high whenever the FSM is not in S_IDLE.
- err  output  1  out-of-range flag, pulsed with rdy; constant 0 unless MEM_BOUNDS_EN is defined.

Behaviour:
- Reset (rst_f=0, takes effect immediately, no clock needed):
  - state goes to S_IDLE.
  - rdy=0, err=0, busy=0, rdata=0.
  - Wait counter and latched request registers cleared.
  - Memory array contents are not reset.
- States, 2-bit encoding: S_IDLE=0, S_WAIT=1, S_RESP=2. Encoding 3 is illegal and goes to S_IDLE on the next edge.
- S_IDLE, on an edge with req=1:
  - Latch we, addr and wdata.
  - cnt <= WAIT_CYC.
  - Go to S_WAIT.
  - With req=0, stay in S_IDLE.
- S_WAIT, cnt>0: cnt <= cnt-1, stay in S_WAIT.
- S_WAIT, cnt==0: perform the access on this edge.
  - Read: rdata <= mem[idx].
  - Write: mem[idx] <= wdata; rdata unchanged.
  - rdy <= 1, go to S_RESP.
- S_RESP: rdy <= 0, err <= 0, go to S_IDLE.
- req is ignored while in S_WAIT and S_RESP; no queuing.
- Latency:
  - req sampled at edge N gives rdy high from edge N+WAIT_CYC+1 for exactly one cycle.
  - WAIT_CYC=0 gives rdy at edge N+1.
  - The earliest next request is sampled at edge N+WAIT_CYC+3.
- idx = latched addr modulo DEPTH (low log2(DEPTH) bits); higher address bits are ignored unless MEM_BOUNDS_EN is defined.
- A write is atomic with rdy: reset asserted before the access edge discards the pending access entirely, with no partial write.
- Reset asserted in S_RESP clears rdy immediately.
- busy is decoded from the state register only, so it is glitch-free.
- Read-after-write to the same address in back-to-back transactions returns the new data.

Optional Feature:
- Macro name: MEM_BOUNDS_EN.
- When defined, a latched addr >= DEPTH is out of range. At the access edge:
  - err <= 1 together with rdy <= 1.
  - Writes are suppressed; memory is unchanged.
  - Reads return rdata <= 32'h0000_0000.
  - Timing is identical to an in-range access.
- When not defined:
  - err is tied to 0.
  - Addresses wrap modulo DEPTH.

Test Plan:
1. Reset: drive rst_f=0 mid-cycle with no clock edge -> rdy=0, busy=0, err=0 and rdata=0 immediately.
2. Write then read, WAIT_CYC=2:
   - Write addr=5, wdata=32'hDEAD_BEEF -> rdy pulses exactly one cycle, 3 edges after req is sampled; busy high for 4 cycles.
   - Then read addr=5 -> rdata=32'hDEAD_BEEF during rdy.
3. Zero wait, WAIT_CYC=0: read addr=0 after preloading 32'h1234_5678 -> rdy at edge N+1 with rdata=32'h1234_5678.
4. req held and toggled during S_WAIT/S_RESP -> exactly one rdy per transaction; a second transaction starts only after busy falls.
5. Reset mid-write: assert rst_f=0 one cycle before the access edge of a write of 32'hAAAA_5555 to addr=7 -> a later read of addr=7 returns the old value and no rdy is seen.
6. Out-of-range addr=256 with DEPTH=256:
   - With MEM_BOUNDS_EN: write sets err=1 with rdy and leaves mem[0] unchanged; read returns rdata=0 with err=1.
   - Without MEM_BOUNDS_EN: the access wraps to mem[0] and err stays 0.
